// File: rtl/ram_loader_if.sv
// Bus bundle between the UART byte source / CPU side and the boot-time RAM loader.
// The master drives bytes and CPU RAM requests; the slave (loader) drives the RAM port and status.
interface ram_loader_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 12
);
   logic                  start;
   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   logic                  cpu_we;
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [DATA_WIDTH-1:0] cpu_din;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_din;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic                  cpu_hold;
   logic [ADDR_WIDTH:0]   words_loaded;

   modport master (
      output start, rx_data, rx_valid, cpu_we, cpu_addr, cpu_din,
      input  rx_ready, ram_we, ram_addr, ram_din, busy, done, err, cpu_hold, words_loaded
   );

   modport slave (
      input  start, rx_data, rx_valid, cpu_we, cpu_addr, cpu_din,
      output rx_ready, ram_we, ram_addr, ram_din, busy, done, err, cpu_hold, words_loaded
   );
endinterface

// File: rtl/ram_loader.sv
// Boot loader: receives a big-endian word count plus words over a byte stream, writes them
// to RAM from address 0 upward, then releases the CPU. Transparent CPU->RAM mux when idle.
module ram_loader #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 12
) (
   input  logic          clk,
   input  logic          rst,
   ram_loader_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE,
      CNT_HI,
      CNT_LO,
      DAT_HI,
      DAT_LO,
      WRITE,
      DONE,
      ERR
   } state_t;

   // Largest legal count is the full RAM; compared in 17 bits so 2^16 capacity still fits.
   localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

   state_t                state;
   logic [15:0]           count;
   logic [ADDR_WIDTH:0]   index;
   logic [ADDR_WIDTH:0]   words_loaded;
   logic [7:0]            word_hi;
   logic [7:0]            word_lo;

   logic                  rx_ready;
   logic                  busy;
   logic                  xfer;
   logic [15:0]           count_full;
   logic [ADDR_WIDTH:0]   index_inc;
   logic                  start_ok;

   assign rx_ready   = (state == CNT_HI) || (state == CNT_LO) ||
                       (state == DAT_HI) || (state == DAT_LO);
   assign busy       = rx_ready || (state == WRITE);
   assign xfer       = rx_ready && bus.rx_valid;
   assign count_full = {count[15:8], bus.rx_data};
   assign index_inc  = index + 1'b1;
   assign start_ok   = bus.start &&
                       ((state == IDLE) || (state == DONE) || (state == ERR));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         count        <= '0;
         index        <= '0;
         words_loaded <= '0;
      end else begin
         case (state)
            IDLE, DONE, ERR: begin
               if (start_ok) begin
                  state        <= CNT_HI;
                  index        <= '0;
                  words_loaded <= '0;
               end
            end
            CNT_HI: begin
               if (xfer) begin
                  count[15:8] <= bus.rx_data;
                  state       <= CNT_LO;
               end
            end
            CNT_LO: begin
               if (xfer) begin
                  count[7:0] <= bus.rx_data;
                  if (count_full == 16'd0)
                     state <= DONE;
                  else if ({1'b0, count_full} > CAPACITY)
                     state <= ERR;
                  else
                     state <= DAT_HI;
               end
            end
            DAT_HI: begin
               if (xfer) state <= DAT_LO;
            end
            DAT_LO: begin
               if (xfer) state <= WRITE;
            end
            WRITE: begin
               index        <= index_inc;
               words_loaded <= words_loaded + 1'b1;
               if (17'(index_inc) == {1'b0, count})
                  state <= DONE;
               else
                  state <= DAT_HI;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Word assembly bytes carry no control meaning, so they are left out of reset.
   always_ff @(posedge clk) begin
      if (state == DAT_HI && xfer) word_hi <= bus.rx_data;
      if (state == DAT_LO && xfer) word_lo <= bus.rx_data;
   end

   assign bus.rx_ready     = rx_ready;
   assign bus.busy         = busy;
   assign bus.done         = (state == DONE);
   assign bus.err          = (state == ERR);
   assign bus.cpu_hold     = (state != DONE);
   assign bus.words_loaded = words_loaded;

   // While loading, the CPU request is dropped entirely; otherwise RAM sees the CPU directly.
   assign bus.ram_we   = busy ? (state == WRITE)            : bus.cpu_we;
   assign bus.ram_addr = busy ? index[ADDR_WIDTH-1:0]       : bus.cpu_addr;
   assign bus.ram_din  = busy ? DATA_WIDTH'({word_hi, word_lo}) : bus.cpu_din;

endmodule

// File: tb/tb_ram_loader.sv
// Randomized bench for ram_loader: a queue-based load model predicts RAM writes and status,
// checked against writes captured on the RAM port and a behavioural RAM array.
module tb_ram_loader;
   localparam int DW  = 16;
   localparam int AW  = 12;
   localparam int CAP = 1 << AW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ram_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
   ram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;

   typedef struct {
      int addr;
      int data;
   } wr_t;

   logic [DW-1:0] mem [0:CAP-1];
   wr_t           wq[$];
   int            rdy_bad = 0;
   int            dbl     = 0;
   logic          prev_we = 1'b0;
   logic [15:0]   words[$];

   always @(posedge clk) if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;

   // Loader-side writes only (busy); each must be a single cycle with rx_ready low.
   always @(negedge clk) begin
      if (bus.busy && bus.ram_we) begin
         wq.push_back('{int'(bus.ram_addr), int'(bus.ram_din)});
         if (bus.rx_ready) rdy_bad <= rdy_bad + 1;
         if (prev_we) dbl <= dbl + 1;
      end
      prev_we <= bus.busy && bus.ram_we;
   end

   task automatic pulse_start();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) begin @(posedge clk); #1; end
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.rx_ready && n < 100);
      if (!bus.rx_ready) begin
         total++; bad++;
         $display("FAIL rx_timeout: rx_ready=%0b want 1 within 100 cycles", bus.rx_ready);
         bus.rx_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin @(negedge clk); n++; end while (bus.busy && n < 50);
      if (bus.busy) begin
         total++; bad++;
         $display("FAIL idle_timeout: busy=%0b want 0", bus.busy);
      end
   endtask

   // Full load scenario; expectations come from the count rules, not from DUT state.
   task automatic run_load(input logic [15:0] cnt, input int gapmax, input bit inject);
      int  base, rb, db, n, badw, firstbad, memerr;
      bit  exp_done;
      base     = wq.size();
      rb       = rdy_bad;
      db       = dbl;
      exp_done = (int'(cnt) <= CAP);
      n        = exp_done ? int'(cnt) : 0;

      pulse_start();
      total++;
      if (bus.busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %0b want 1", bus.busy); end
      if (bus.cpu_we) begin
         total++;
         if (bus.ram_we !== 1'b0) begin bad++; $display("FAIL cpu_we_blocked: ram_we=%0b want 0", bus.ram_we); end
      end

      send_byte(cnt[15:8], $urandom_range(gapmax, 0));
      send_byte(cnt[7:0],  $urandom_range(gapmax, 0));
      for (int i = 0; i < n; i++) begin
         send_byte(words[i][15:8], $urandom_range(gapmax, 0));
         if (inject && i == 0) pulse_start();
         send_byte(words[i][7:0], $urandom_range(gapmax, 0));
      end
      wait_idle();

      total++;
      if (wq.size() - base !== n) begin
         bad++; $display("FAIL write_count: got %0d want %0d", wq.size() - base, n);
      end
      badw = 0; firstbad = -1;
      for (int i = 0; i < n && base + i < wq.size(); i++)
         if (wq[base+i].addr !== i || wq[base+i].data !== int'(words[i])) begin
            badw++; if (firstbad < 0) firstbad = i;
         end
      total++;
      if (badw !== 0) begin
         bad++; $display("FAIL write_seq: %0d bad writes, first at %0d (addr %0h data %0h) want data %0h",
                         badw, firstbad, wq[base+firstbad].addr, wq[base+firstbad].data, words[firstbad]);
      end
      memerr = 0;
      for (int i = 0; i < n; i++) if (mem[i] !== words[i]) memerr++;
      total++;
      if (memerr !== 0) begin bad++; $display("FAIL ram_readback: got %0d bad words want 0", memerr); end
      total++;
      if (bus.done !== exp_done) begin bad++; $display("FAIL done: got %0b want %0b", bus.done, exp_done); end
      total++;
      if (bus.err !== !exp_done) begin bad++; $display("FAIL err: got %0b want %0b", bus.err, !exp_done); end
      total++;
      if (bus.cpu_hold !== !exp_done) begin bad++; $display("FAIL cpu_hold: got %0b want %0b", bus.cpu_hold, !exp_done); end
      total++;
      if (bus.words_loaded !== (AW+1)'(n)) begin
         bad++; $display("FAIL words_loaded: got %0d want %0d", bus.words_loaded, n);
      end
      total++;
      if (rdy_bad - rb !== 0) begin bad++; $display("FAIL ready_in_write: got %0d want 0", rdy_bad - rb); end
      total++;
      if (dbl - db !== 0) begin bad++; $display("FAIL we_pulse_width: got %0d long pulses want 0", dbl - db); end
   endtask

   task automatic rand_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(16'($urandom));
   endtask

   task automatic test_reset();
      total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 ||
          bus.cpu_hold !== 1'b1 || bus.rx_ready !== 1'b0 || bus.words_loaded !== '0) begin
         bad++; $display("FAIL reset_state: busy=%0b done=%0b err=%0b hold=%0b rdy=%0b wl=%0d want 0 0 0 1 0 0",
                         bus.busy, bus.done, bus.err, bus.cpu_hold, bus.rx_ready, bus.words_loaded);
      end
   endtask

   task automatic test_basic();
      words = '{16'h1234, 16'hABCD, 16'h0001};
      run_load(16'd3, 0, 1'b0);
   endtask

   task automatic test_count_limits();
      words.delete();
      run_load(16'd0, 1, 1'b0);
      run_load(16'h1001, 1, 1'b0);
      rand_words(CAP);
      run_load(16'h1000, 0, 1'b0);
      total++;
      if (wq.size() == 0 || wq[wq.size()-1].addr !== CAP - 1) begin
         bad++; $display("FAIL last_addr: got %0h want %0h", (wq.size() == 0) ? -1 : wq[wq.size()-1].addr, CAP - 1);
      end
   endtask

   task automatic test_cpu_mux();
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = AW'(5); d = 16'h5A5A;
      bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_din = d;
      #1;
      total++;
      if (bus.ram_we !== 1'b1 || bus.ram_addr !== a || bus.ram_din !== d) begin
         bad++; $display("FAIL cpu_passthru: we=%0b addr=%0h din=%0h want 1 %0h %0h",
                         bus.ram_we, bus.ram_addr, bus.ram_din, a, d);
      end
      rand_words(2);
      bus.cpu_addr = AW'($urandom_range(CAP-1, 16));
      run_load(16'd2, 2, 1'b0);
      bus.cpu_we = 1'b0;
   endtask

   task automatic test_gaps();
      rand_words(2);
      run_load(16'd2, 5, 1'b1);
      rand_words(5);
      run_load(16'd5, 3, 1'b0);
   endtask

   task automatic test_reset_mid_load();
      rand_words(3);
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h03, 0);
      send_byte(words[0][15:8], 0);
      send_byte(words[0][7:0], 0);
      send_byte(words[1][15:8], 1);
      total++;
      if (bus.busy !== 1'b1 || bus.words_loaded !== (AW+1)'(1)) begin
         bad++; $display("FAIL mid_load_state: busy=%0b wl=%0d want 1 1", bus.busy, bus.words_loaded);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (bus.busy !== 1'b0 || bus.cpu_hold !== 1'b1 || bus.words_loaded !== '0 || bus.rx_ready !== 1'b0) begin
         bad++; $display("FAIL async_reset: busy=%0b hold=%0b wl=%0d rdy=%0b want 0 1 0 0",
                         bus.busy, bus.cpu_hold, bus.words_loaded, bus.rx_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      rand_words(3);
      run_load(16'd3, 2, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.rx_data = '0; bus.rx_valid = 1'b0;
      bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
      #1;
      test_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      test_reset();
      test_basic();
      test_count_limits();
      test_cpu_mux();
      test_gaps();
      test_reset_mid_load();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
